// File: rtl/float_batch_feeder_if.sv
// Upstream word handshake plus sorter-facing start/stream bundle for float_batch_feeder.
interface float_batch_feeder_if #(
   parameter int L = 32,
   parameter int S = 5
);
   logic         s_valid;
   logic [L-1:0] s_data;
   logic         s_ready;
   logic         flush;
   logic         start;
   logic [L-1:0] inp_raw;
   logic         busy;
   logic [S-1:0] fill_cnt;

   modport master (
      output s_valid, s_data, flush,
      input  s_ready, start, inp_raw, busy, fill_cnt
   );

   modport slave (
      input  s_valid, s_data, flush,
      output s_ready, start, inp_raw, busy, fill_cnt
   );
endinterface

// File: rtl/float_batch_feeder.sv
// Buffers K float words, pulses start, streams them to the sorter, then holds for settle.
// Optional macro FLUSH_DENORM_EN: store zero/subnormal words as signed zero.
module float_batch_feeder #(
   parameter int          Nk       = 23,
   parameter int          M        = 8,
   parameter int          L        = Nk + M + 1,
   parameter int          K        = 10,
   parameter int          S        = $clog2(K) + 1,
   parameter int          HOLD_CYC = K + 4,
   parameter logic [L-1:0] PAD_WORD = 'h7F800000
) (
   input logic             clk,
   input logic             reset,
   float_batch_feeder_if.slave bus
);
   localparam int          HW = $clog2(HOLD_CYC + 1);
   localparam int unsigned KU = K;

   typedef enum logic [1:0] {FILL, START, STREAM, HOLD} state_t;

   state_t        state;
   logic [L-1:0]  mem [K];
   logic [S-1:0]  idx;
   logic [HW-1:0] hold_cnt;

   logic [L-1:0]  wdata;
   logic [L-1:0]  rd_word;
   logic          wr;
   logic          go;
   logic          pad;
   logic [S-1:0]  eff_cnt;

   always_comb begin
      wdata = bus.s_data;
`ifdef FLUSH_DENORM_EN
      if (bus.s_data[L-2 -: M] == '0)
         wdata = {bus.s_data[L-1], {(L-1){1'b0}}};
`endif
      wr      = (state == FILL) && bus.s_ready && bus.s_valid && (bus.fill_cnt < S'(K));
      eff_cnt = bus.fill_cnt + S'(wr);
      // A same-cycle word counts toward the batch before the pad boundary is taken
      go      = (state == FILL) && ((eff_cnt == S'(K)) || (bus.flush && (eff_cnt != '0)));
      pad     = go && bus.flush && (eff_cnt != S'(K));
      rd_word = '0;
      for (int unsigned i = 0; i < KU; i++)
         if (S'(i) == idx) rd_word = mem[i];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FILL;
         bus.s_ready <= 1'b1;
         bus.start   <= 1'b0;
         bus.inp_raw <= '0;
         bus.busy    <= 1'b0;
         bus.fill_cnt <= '0;
         idx         <= '0;
         hold_cnt    <= '0;
         for (int unsigned i = 0; i < KU; i++) mem[i] <= '0;
      end else begin
         bus.start <= 1'b0;
         case (state)
            FILL: begin
               for (int unsigned i = 0; i < KU; i++) begin
                  if (wr && (S'(i) == bus.fill_cnt))
                     mem[i] <= wdata;
                  else if (pad && (S'(i) >= eff_cnt))
                     mem[i] <= PAD_WORD;
               end
               bus.fill_cnt <= eff_cnt;
               if (go) begin
                  state       <= START;
                  bus.s_ready <= 1'b0;
                  bus.start   <= 1'b1;
                  bus.busy    <= 1'b1;
               end
            end
            START: begin
               state       <= STREAM;
               bus.inp_raw <= mem[0];
               idx         <= S'(1);
            end
            STREAM: begin
               if (idx == S'(K)) begin
                  state       <= HOLD;
                  bus.inp_raw <= '0;
                  idx         <= '0;
                  hold_cnt    <= '0;
               end else begin
                  bus.inp_raw <= rd_word;
                  idx         <= idx + S'(1);
               end
            end
            HOLD: begin
               if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                  state        <= FILL;
                  bus.fill_cnt <= '0;
                  bus.s_ready  <= 1'b1;
                  bus.busy     <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_float_batch_feeder.sv
// Directed + randomized bench for float_batch_feeder against a batch-level reference model.
// Honours FLUSH_DENORM_EN when computing expected stored words.
module tb_float_batch_feeder;
   localparam int          K        = 10;
   localparam int          L        = 32;
   localparam int          S        = $clog2(K) + 1;
   localparam int          HOLD_CYC = K + 4;
   localparam logic [31:0] PAD      = 32'h7F800000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   float_batch_feeder_if #(.L(L), .S(S)) bus ();

   float_batch_feeder #(.K(K)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] q_in[$];

   function automatic logic [31:0] ref_store(input logic [31:0] w);
`ifdef FLUSH_DENORM_EN
      if (w[30:23] == 8'h00) return {w[31], 31'b0};
`endif
      return w;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[30:23] = 8'h00;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w, input logic fl, input int exp_cnt);
      int g;
      g = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      bus.flush   = fl;
      while (bus.s_ready !== 1'b1 && g < 100) begin
         tick();
         g++;
      end
      chk("ready_wait", 32'(bus.s_ready), 32'd1);
      tick();
      bus.flush = 1'b0;
      if (exp_cnt >= 0) chk("fill_cnt", 32'(bus.fill_cnt), 32'(exp_cnt));
   endtask

   // mode 0: full batch, 1: flush after last word, 2: flush together with last word
   task automatic load(input int first, input int n, input int mode);
      for (int i = first; i < n; i++) begin
         if (mode == 2 && i == n - 1) send(q_in[i], 1'b1, -1);
         else                         send(q_in[i], 1'b0, i + 1);
      end
      bus.s_valid = 1'b0;
      if (mode == 1) begin
         bus.flush = 1'b1;
         tick();
         bus.flush = 1'b0;
      end
   endtask

   task automatic stream_check(input int n, input bit bp, input logic [31:0] bpw);
      logic [31:0] e;
      chk("start_pulse", 32'(bus.start), 32'd1);
      chk("start_inp", bus.inp_raw, 32'd0);
      chk("start_busy", 32'(bus.busy), 32'd1);
      chk("start_ready", 32'(bus.s_ready), 32'd0);
      if (bp) begin
         bus.s_valid = 1'b1;
         bus.s_data  = bpw;
      end
      for (int i = 0; i < K; i++) begin
         tick();
         e = (i < n) ? ref_store(q_in[i]) : PAD;
         chk($sformatf("word%0d", i), bus.inp_raw, e);
         chk("stream_start", 32'(bus.start), 32'd0);
         chk("stream_ready", 32'(bus.s_ready), 32'd0);
      end
      for (int h = 0; h < HOLD_CYC; h++) begin
         tick();
         chk("hold_inp", bus.inp_raw, 32'd0);
         chk("hold_busy", 32'(bus.busy), 32'd1);
         chk("hold_ready", 32'(bus.s_ready), 32'd0);
      end
      tick();
      chk("fill_busy", 32'(bus.busy), 32'd0);
      chk("fill_ready", 32'(bus.s_ready), 32'd1);
      chk("fill_cnt_clr", 32'(bus.fill_cnt), 32'd0);
      chk("fill_inp", bus.inp_raw, 32'd0);
      if (bp) begin
         tick();
         chk("bp_accept", 32'(bus.fill_cnt), 32'd1);
         bus.s_valid = 1'b0;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int mode;
      logic [31:0] bpw;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.flush   = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(bus.s_ready), 32'd1);
      chk("rst_start", 32'(bus.start), 32'd0);
      chk("rst_inp", bus.inp_raw, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_fill", 32'(bus.fill_cnt), 32'd0);
      reset = 1'b1;
      tick();

      q_in = '{32'h40D00000, 32'hC1A81687, 32'hC1A00000, 32'h41900000, 32'h41400000,
               32'hBF800000, 32'h41500FF0, 32'hC1200000, 32'h00000000, 32'h3F800000};
      load(0, K, 0);
      stream_check(K, 1'b0, '0);

      q_in = '{32'h40D00000, 32'hBF800000, 32'h41400000};
      load(0, 3, 1);
      stream_check(3, 1'b0, '0);

      q_in.delete();
      for (int i = 0; i < 5; i++) q_in.push_back(rand_word());
      load(0, 5, 2);
      stream_check(5, 1'b0, '0);

      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("flush0_start", 32'(bus.start), 32'd0);
         chk("flush0_busy", 32'(bus.busy), 32'd0);
         tick();
      end
      chk("flush0_ready", 32'(bus.s_ready), 32'd1);

      q_in.delete();
      for (int i = 0; i < K; i++) q_in.push_back(rand_word());
      load(0, K, 0);
      bpw = rand_word();
      stream_check(K, 1'b1, bpw);
      q_in.delete();
      q_in.push_back(bpw);
      for (int i = 1; i < K; i++) q_in.push_back(rand_word());
      load(1, K, 0);
      stream_check(K, 1'b0, '0);

      q_in = '{32'h80000001, 32'h00400000, 32'h3F800000};
      load(0, 3, 1);
      stream_check(3, 1'b0, '0);

      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, K);
         mode = (n == K) ? 0 : $urandom_range(1, 2);
         q_in.delete();
         for (int i = 0; i < n; i++) q_in.push_back(rand_word());
         load(0, n, mode);
         stream_check(n, 1'b0, '0);
      end

      q_in.delete();
      for (int i = 0; i < K; i++) q_in.push_back(rand_word());
      load(0, K, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_inp", bus.inp_raw, 32'd0);
      chk("mid_rst_start", 32'(bus.start), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_ready", 32'(bus.s_ready), 32'd1);
      chk("mid_rst_fill", 32'(bus.fill_cnt), 32'd0);
      tick();
      chk("rst_hold_inp", bus.inp_raw, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 2 * K; i++) begin
         tick();
         chk("post_rst_start", 32'(bus.start), 32'd0);
         chk("post_rst_inp", bus.inp_raw, 32'd0);
      end

      q_in.delete();
      for (int i = 0; i < K; i++) q_in.push_back(rand_word());
      load(0, K, 0);
      stream_check(K, 1'b0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
